// File: rtl/irq_ctrl_n.sv
// irq_ctrl_n -- parametrised vectored interrupt controller.
//
// Latches up to N_IRQ requests (level or rising-edge per channel), masks them
// with the core's mie, picks the lowest eligible index, and presents it to the
// core as int_o / mcause_o. On the core's end-of-service strobe it pulses the
// matching int_fin_o bit for one cycle, then waits HOLDOFF idle cycles before
// the next dispatch.
//
// Ports:
//   clk_i      - system clock, rising edge
//   rst_i      - synchronous active-high reset
//   int_req_i  - raw requests from peripherals [N_IRQ-1:0]
//   mie_i      - core interrupt-enable mask, bits [N_IRQ-1:0] used
//   int_rst_i  - core end-of-service strobe
//   int_o      - interrupt request to the core
//   mcause_o   - cause of the current interrupt {1'b1, CAUSE_BASE+channel}
//   int_fin_o  - one-hot, one-cycle completion pulse to the serviced source

module irq_ctrl_n #(
    parameter int unsigned N_IRQ      = 16,
    parameter logic [31:0] EDGE_MASK  = 32'h0,
    parameter int unsigned CAUSE_BASE = 16,
    parameter int unsigned HOLDOFF    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [31:0]      mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] int_fin_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FIN,
        HOLD
    } state_t;

    localparam logic [N_IRQ-1:0] EDGE = EDGE_MASK[N_IRQ-1:0];

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] cur_oh;
    logic [N_IRQ-1:0] clr;
    logic [4:0]       cur_q, cur_d;
    logic [4:0]       win;
    logic             found;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      mcause_q, mcause_d;

    generate
        if (N_IRQ < 32) begin : g_mie_tail
            logic unused_mie;
            assign unused_mie = ^mie_i[31:N_IRQ];
        end
    endgenerate

    assign elig = pend_q & mie_i[N_IRQ-1:0];

    // Fixed priority: lowest set index wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            if (elig[k] && !found) begin
                win   = 5'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        cur_oh = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            cur_oh[k] = (cur_q == 5'(k));
        end
    end

    // Edge-pending bit of the serviced channel clears on the completion edge;
    // a rise on the same edge re-sets it so the new event is not lost.
    assign clr    = (state_q == ACTIVE && int_rst_i) ? cur_oh : '0;
    assign pend_d = (((pend_q & ~clr) | (int_req_i & ~prev_q)) & EDGE)
                  | (int_req_i & ~EDGE);

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        mcause_d = mcause_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    cur_d    = win;
                    mcause_d = {1'b1, 31'(CAUSE_BASE + 32'(win))};
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (int_rst_i) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (HOLDOFF == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                    cnt_d   = 4'(HOLDOFF);
                end
            end
            HOLD: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            prev_q   <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            prev_q   <= int_req_i;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            mcause_q <= mcause_d;
        end
    end

    assign int_o     = (state_q == ACTIVE);
    assign int_fin_o = (state_q == FIN) ? cur_oh : '0;
    assign mcause_o  = mcause_q;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// tb_irq_ctrl_n -- self-checking bench for irq_ctrl_n.
//
// A timestamp-based reference model tracks pending bits, the channel in
// service, and the earliest cycle at which a new dispatch may happen. Every
// cycle the DUT outputs are compared against it; directed sequences add
// explicit constant checks for the key scenarios, followed by random traffic.

module tb_irq_ctrl_n;

    localparam int unsigned N  = 16;
    localparam logic [15:0] EM = 16'h00F0;
    localparam int unsigned CB = 16;
    localparam int unsigned HO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [31:0] mie;
    logic        irst;
    logic        int_o;
    logic [31:0] mcause;
    logic [15:0] fin;

    always #5 clk = ~clk;

    irq_ctrl_n #(
        .N_IRQ      (N),
        .EDGE_MASK  (32'h0000_00F0),
        .CAUSE_BASE (CB),
        .HOLDOFF    (HO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .int_req_i (req),
        .mie_i     (mie),
        .int_rst_i (irst),
        .int_o     (int_o),
        .mcause_o  (mcause),
        .int_fin_o (fin)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_pend  = '0;
    logic [15:0] m_prev  = '0;
    logic        m_act   = 1'b0;
    int          m_cur   = 0;
    logic [31:0] m_cause = '0;
    logic [15:0] m_fin   = '0;
    int          cyc     = 0;
    int          ready_at = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_update();
        logic [15:0] elig;
        logic [15:0] clr;
        logic [15:0] rise;
        cyc++;
        if (rst) begin
            m_pend   = '0;
            m_prev   = '0;
            m_act    = 1'b0;
            m_cause  = '0;
            m_fin    = '0;
            ready_at = cyc + 1;
        end else begin
            elig  = m_pend & mie[15:0];
            clr   = '0;
            m_fin = '0;
            if (m_act) begin
                if (irst) begin
                    m_act    = 1'b0;
                    m_fin    = 16'(1) << m_cur;
                    clr      = m_fin;
                    ready_at = cyc + int'(HO) + 2;
                end
            end else if (cyc >= ready_at && elig != 0) begin
                for (int i = 15; i >= 0; i--) begin
                    if (elig[i]) m_cur = i;
                end
                m_act   = 1'b1;
                m_cause = 32'h8000_0000 | 32'(CB + 32'(m_cur));
            end
            rise   = req & ~m_prev;
            m_pend = (((m_pend & ~clr) | rise) & EM) | (req & ~EM);
            m_prev = req;
        end
    endtask

    task automatic step(input logic r, input logic [15:0] q, input logic [31:0] m, input logic ir);
        rst  = r;
        req  = q;
        mie  = m;
        irst = ir;
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("m_int_o",  {31'b0, int_o}, {31'b0, m_act});
        chk("m_mcause", mcause, m_cause);
        chk("m_fin",    {16'b0, fin}, {16'b0, m_fin});
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 16'hFFFF, 32'h0, 1'b0);
        chk("rst_int_o",  {31'b0, int_o}, 32'h0);
        chk("rst_mcause", mcause, 32'h0);
        chk("rst_fin",    {16'b0, fin}, 32'h0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        mie  = '0;
        irst = 1'b0;

        // Reset and idle with everything masked
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 16'($urandom), 32'h0, 1'b0);
        chk("idle_int_o", {31'b0, int_o}, 32'h0);

        // Single level request on channel 3
        do_reset();
        step(1'b0, 16'h0008, 32'h8, 1'b0);
        chk("lvl_lat_e0", {31'b0, int_o}, 32'h0);
        step(1'b0, 16'h0008, 32'h8, 1'b0);
        chk("lvl_int_o", {31'b0, int_o}, 32'h1);
        chk("lvl_cause", mcause, 32'h8000_0013);
        step(1'b0, 16'h0008, 32'h8, 1'b0);
        step(1'b0, 16'h0008, 32'h8, 1'b1);
        chk("lvl_fin", {16'b0, fin}, 32'h0008);
        chk("lvl_int_lo", {31'b0, int_o}, 32'h0);
        step(1'b0, 16'h0000, 32'h8, 1'b0);
        chk("lvl_fin_clr", {16'b0, fin}, 32'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 32'h8, 1'b0);
        chk("lvl_no_redisp", {31'b0, int_o}, 32'h0);

        // Priority and no preemption
        do_reset();
        step(1'b0, 16'h0024, 32'hFFFF, 1'b0);
        step(1'b0, 16'h0024, 32'hFFFF, 1'b0);
        chk("pri_first", mcause, 32'h8000_0012);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0025, 32'hFFFF, 1'b0);
            chk("pri_nopreempt", mcause, 32'h8000_0012);
        end
        step(1'b0, 16'h0021, 32'hFFFF, 1'b1);
        chk("pri_fin2", {16'b0, fin}, 32'h0004);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0021, 32'hFFFF, 1'b0);
        chk("pri_hold", {31'b0, int_o}, 32'h0);
        step(1'b0, 16'h0021, 32'hFFFF, 1'b0);
        chk("pri_ch0", mcause, 32'h8000_0010);
        step(1'b0, 16'h0020, 32'hFFFF, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0020, 32'hFFFF, 1'b0);
        chk("pri_ch5", mcause, 32'h8000_0015);
        step(1'b0, 16'h0000, 32'hFFFF, 1'b1);
        chk("pri_fin5", {16'b0, fin}, 32'h0020);

        // Edge capture on channel 7
        do_reset();
        step(1'b0, 16'h0080, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 32'h0, 1'b0);
        chk("edge_masked", {31'b0, int_o}, 32'h0);
        step(1'b0, 16'h0000, 32'h80, 1'b0);
        chk("edge_disp", mcause, 32'h8000_0017);
        step(1'b0, 16'h0000, 32'h80, 1'b0);
        step(1'b0, 16'h0080, 32'h80, 1'b1);
        chk("edge_fin", {16'b0, fin}, 32'h0080);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 32'h80, 1'b0);
        chk("edge_hold", {31'b0, int_o}, 32'h0);
        step(1'b0, 16'h0000, 32'h80, 1'b0);
        chk("edge_second", {31'b0, int_o}, 32'h1);
        step(1'b0, 16'h0000, 32'h80, 1'b1);

        // Hold-off with level channel 1 held through completion
        do_reset();
        step(1'b0, 16'h0002, 32'h2, 1'b0);
        step(1'b0, 16'h0002, 32'h2, 1'b0);
        chk("ho_cause", mcause, 32'h8000_0011);
        step(1'b0, 16'h0002, 32'h2, 1'b0);
        step(1'b0, 16'h0002, 32'h2, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 16'h0002, 32'h2, 1'b0);
            chk("ho_early", {31'b0, int_o}, 32'h0);
        end
        step(1'b0, 16'h0002, 32'h2, 1'b0);
        chk("ho_reassert", {31'b0, int_o}, 32'h1);

        // Reset mid-service clears edge pending bits
        do_reset();
        step(1'b0, 16'h0080, 32'h80, 1'b0);
        step(1'b0, 16'h0000, 32'h80, 1'b0);
        chk("rms_active", {31'b0, int_o}, 32'h1);
        step(1'b0, 16'h0040, 32'h80, 1'b0);
        step(1'b0, 16'h0000, 32'h80, 1'b0);
        step(1'b1, 16'h0000, 32'h80, 1'b0);
        chk("rms_int_o",  {31'b0, int_o}, 32'h0);
        chk("rms_mcause", mcause, 32'h0);
        chk("rms_fin",    {16'b0, fin}, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 32'hFF, 1'b0);
        chk("rms_no_disp", {31'b0, int_o}, 32'h0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 16'($urandom) & 16'($urandom),
                 $urandom,
                 ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl_n.md
# irq_ctrl_n

Parametrised vectored interrupt controller between the platform's interrupt sources (keyboard, timers, other peripherals) and `cpu_main`. It latches up to `N_IRQ` requests, each in level or edge mode, and masks them with the core's `mie`. It arbitrates by fixed priority, drives `INT_` and `mcause` to the core, and returns a per-channel completion pulse when the core signals end-of-service via `INT_RST`. It replaces the single-mode controller with configurable width, per-channel trigger mode, a cause base and a post-service hold-off.

## Interface
- `N_IRQ`, 16 — number of request channels, legal 1..32.
- `EDGE_MASK`, 32'h0 — bit k=1: channel k is rising-edge triggered; 0: level (active-high).
- `CAUSE_BASE`, 16 — code reported for channel 0; channel k reports `CAUSE_BASE+k`.
- `HOLDOFF`, 2 — idle cycles after each completion before the next dispatch, legal 0..15.
- `clk_i` in 1 — system clock; all state changes on its rising edge. One clock domain only.
- `rst_i` in 1 — synchronous, active-high reset.
- `int_req_i` in N_IRQ — raw requests from peripherals, synchronous to `clk_i`.
- `mie_i` in 32 — enable mask from the core CSR; bits [N_IRQ-1:0] used.
- `int_rst_i` in 1 — core end-of-service strobe (mret of an interrupt).
- `int_o` in/out: out 1 — interrupt request to the core (`INT_`).
- `mcause_o` out 32 — cause of the current interrupt.
- `int_fin_o` out N_IRQ — one-hot, one-cycle completion pulse to the serviced source.

## Operation
- Pending register `pend[N_IRQ-1:0]`:
  - Level channel: `pend[k]` is `int_req_i[k]` registered each cycle, with no stickiness.
  - Edge channel: `prev[k]` holds the last sample. `pend[k]` sets on `int_req_i[k] & ~prev[k]` and clears only in the FIN cycle of channel k.
  - If a rise on channel k coincides with its FIN clear, the set wins, so no event is lost.
- Eligible vector: `pend & mie_i[N_IRQ-1:0]`. Winner is the lowest set index.
- FSM states: IDLE, ACTIVE, FIN, HOLD.
  - IDLE: if eligible is non-zero, capture the winner in `cur`, set `int_o=1`, set `mcause_o = {1'b1, 31'(CAUSE_BASE+cur)}`, go ACTIVE. Otherwise stay. `int_rst_i` is ignored.
  - ACTIVE: `int_o` and `mcause_o` hold. Changes to `mie_i`, `pend` or higher-priority requests have no effect, because there is no preemption. On `int_rst_i=1`:
    - `int_o` goes to 0.
    - `int_fin_o[cur]` goes to 1.
    - Edge channel `cur` has `pend` cleared.
    - Go FIN.
  - FIN, 1 cycle: `int_fin_o` returns to 0. Go HOLD with counter `HOLDOFF`; if `HOLDOFF`=0, go IDLE.
  - HOLD: decrement the counter; go IDLE when it reaches 1. No dispatch occurs, which gives level sources time to drop their request after `int_fin_o`.
- `mcause_o` keeps its last value outside ACTIVE.
- `CAUSE_BASE+k` is computed at 31-bit width and wraps modulo 2^31.
- `int_rst_i` held high for several cycles is treated as one completion; it is evaluated only in ACTIVE.

## Timing
- Reset: `int_o`=0, `mcause_o`=0, `int_fin_o`=0, `pend`=0, `prev`=0, state IDLE, counter 0. Reset asserted in any state aborts service immediately with no `int_fin_o` pulse.
- Request latency: request high before edge E0 sets `pend` after E0. If the request is enabled and the FSM is in IDLE, `int_o` and `mcause_o` are valid after E1, i.e. 2 cycles.
- `mie_i` is used combinationally in IDLE arbitration, so enabling an already-pending channel dispatches at the next edge.
- Completion: `int_rst_i` sampled at edge Ek:
  - `int_o` falls and `int_fin_o` pulses after Ek.
  - `int_fin_o` clears after Ek+1.
  - Earliest re-assertion of `int_o` is after Ek+HOLDOFF+2.
- Back-to-back: with two channels pending, the lower index is served first. The other is dispatched after the hold-off, provided its `pend` and `mie_i` are still set.
- A level request that drops before dispatch is lost by design. An edge request is held until served.

## Test plan
- Reset/idle: `rst_i`=1 for 3 cycles with `int_req_i`=all-ones -> all outputs 0. After release with `mie_i`=0 -> `int_o` stays 0 for 20 cycles.
- Single level request: `mie_i`=32'h8, `int_req_i[3]`=1 before E0 -> `int_o`=1 and `mcause_o`=32'h8000_0013 after E1. `int_rst_i` pulse at Ek -> `int_fin_o`=16'h0008 for exactly one cycle. Source drops its request -> no redispatch.
- Priority/no preemption:
  - Channels 5 and 2 pending, all enabled -> cause 0x12 served first.
  - Raising channel 0 during ACTIVE -> `mcause_o` unchanged.
  - After completion plus `HOLDOFF` -> channel 0 is served (cause 0x10), then channel 5.
- Edge capture: `EDGE_MASK` bit 7 set, 1-cycle pulse on `int_req_i[7]` while `mie_i[7]`=0 -> no dispatch. Setting `mie_i[7]` later -> dispatch with cause 0x17. A second pulse coinciding with FIN -> a second dispatch follows.
- Hold-off: `HOLDOFF`=2, level channel 1 held high through completion at Ek -> `int_o` re-asserts exactly after Ek+4 and not before.
- Reset mid-service: `rst_i` in ACTIVE -> after that edge `int_o`=0, `mcause_o`=0, `int_fin_o`=0, and edge `pend` bits are cleared.
